// File: rtl/rx_frame_delineator_if.sv
// rx_frame_delineator_if
//   Bundles the raw XGMII receive lanes and the delineated stream/strobes that
//   come out of the frame delineator.
//   master : XGMII source / downstream consumer side (drives rxd/rxc, sees strobes)
//   slave  : the delineator itself
//   xgmii_rxd/xgmii_rxc   raw 64-bit data + 8 lane-control bits, lane 0 first
//   rxd64_d2              data delayed by exactly 2 cycles
//   receiving_d2          rxd64_d2 carries 8 valid frame bytes
//   get_terminator        rxd64_d2 is the terminating word (1-cycle pulse)
//   terminator_location   lane of /T/ = valid bytes in that word
//   wait_crc_check        3-cycle window after get_terminator
//   frame_bytes           bytes after SFD incl. FCS, valid with get_terminator
//   frame_error           aborted frame pulse
//   frame_too_long        oversize frame pulse
interface rx_frame_delineator_if;
  logic [63:0] xgmii_rxd;
  logic [7:0]  xgmii_rxc;
  logic [63:0] rxd64_d2;
  logic        receiving_d2;
  logic        get_terminator;
  logic [2:0]  terminator_location;
  logic        wait_crc_check;
  logic [15:0] frame_bytes;
  logic        frame_error;
  logic        frame_too_long;

  modport master (
    output xgmii_rxd, xgmii_rxc,
    input  rxd64_d2, receiving_d2, get_terminator, terminator_location,
           wait_crc_check, frame_bytes, frame_error, frame_too_long
  );

  modport slave (
    input  xgmii_rxd, xgmii_rxc,
    output rxd64_d2, receiving_d2, get_terminator, terminator_location,
           wait_crc_check, frame_bytes, frame_error, frame_too_long
  );
endinterface

// File: rtl/rx_frame_delineator.sv
// rx_frame_delineator
//   Front end of the 10G receive path. Decodes raw XGMII words, tracks frame
//   start (/S/ + preamble + SFD) and end (/T/), and emits a 2-cycle-delayed
//   data stream with framing strobes for the CRC checker. Flags aborted
//   frames (stray control characters, early /S/) and oversize frames.
// Ports
//   rxclk   in  receive clock, posedge
//   reset   in  asynchronous, active-high
//   bus     rx_frame_delineator_if.slave (XGMII in, stream + strobes out)
// Parameters
//   MAX_WORDS  full data words allowed after the SFD word before the frame is
//              declared too long (190 words = 1520 bytes)
module rx_frame_delineator #(
  parameter int MAX_WORDS = 190
) (
  input  logic                 rxclk,
  input  logic                 reset,
  rx_frame_delineator_if.slave bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RECV    = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  localparam int CW = $clog2(MAX_WORDS + 1);

  // /S/ in lane 0, six preamble bytes, SFD in lane 7
  localparam logic [63:0] START_WORD = {8'hD5, {6{8'h55}}, 8'hFB};

  // ---------------------------------------------------------------------------
  // Combinational decode of the raw word
  // ---------------------------------------------------------------------------
  logic       is_start;
  logic       any_ctrl;
  logic       term_ok;
  logic [2:0] term_lane;

  assign is_start = (bus.xgmii_rxc == 8'h01) && (bus.xgmii_rxd == START_WORD);
  assign any_ctrl = |bus.xgmii_rxc;

  // The lowest control lane is the only candidate for /T/: anything below it
  // is data by construction, anything above it (idles) is tolerated. If that
  // lane is not /T/, the word is a framing error.
  always_comb begin
    term_lane = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (bus.xgmii_rxc[k]) term_lane = 3'(k);
    end
    term_ok = any_ctrl && (bus.xgmii_rxd[{term_lane, 3'b000} +: 8] == 8'hFD);
  end

  // ---------------------------------------------------------------------------
  // Stage d1: FSM and registered decode results
  // ---------------------------------------------------------------------------
  logic [1:0]    state;
  logic [CW-1:0] wcnt;
  logic [63:0]   rxd_d1;
  logic          rcv_d1;
  logic          term_d1;
  logic          err_d1;
  logic          tl_d1;
  logic [2:0]    loc_d1;
  logic [15:0]   bytes_d1;

  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      wcnt     <= '0;
      rxd_d1   <= '0;
      rcv_d1   <= 1'b0;
      term_d1  <= 1'b0;
      err_d1   <= 1'b0;
      tl_d1    <= 1'b0;
      loc_d1   <= 3'd0;
      bytes_d1 <= 16'd0;
    end else begin
      rxd_d1   <= bus.xgmii_rxd;
      rcv_d1   <= 1'b0;
      term_d1  <= 1'b0;
      err_d1   <= 1'b0;
      tl_d1    <= 1'b0;
      loc_d1   <= 3'd0;
      bytes_d1 <= 16'd0;
      case (state)
        S_IDLE: begin
          // A /S/ with a corrupted preamble is silently ignored.
          if (is_start) begin
            state <= S_RECV;
            wcnt  <= '0;
          end
        end
        S_RECV: begin
          if (!any_ctrl) begin
            if (wcnt == CW'(MAX_WORDS)) begin
              tl_d1 <= 1'b1;
              state <= S_DISCARD;
            end else begin
              rcv_d1 <= 1'b1;
              wcnt   <= wcnt + 1'b1;
            end
          end else if (term_ok) begin
            term_d1  <= 1'b1;
            loc_d1   <= term_lane;
            bytes_d1 <= 16'({wcnt, 3'b000}) + 16'(term_lane);
            state    <= S_IDLE;
          end else begin
            // Covers /E/, stray control and an early /S/; the /S/ word is
            // deliberately not treated as a new start.
            err_d1 <= 1'b1;
            state  <= S_IDLE;
          end
        end
        S_DISCARD: begin
          // Wait out the oversize frame; first control word ends it.
          if (any_ctrl) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Stage d2: output registers and CRC verdict window
  // ---------------------------------------------------------------------------
  logic [63:0] rxd_d2;
  logic        rcv_d2;
  logic        term_d2;
  logic        err_d2;
  logic        tl_d2;
  logic [2:0]  loc_d2;
  logic [15:0] bytes_d2;
  logic [1:0]  wcc_cnt;

  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      rxd_d2   <= '0;
      rcv_d2   <= 1'b0;
      term_d2  <= 1'b0;
      err_d2   <= 1'b0;
      tl_d2    <= 1'b0;
      loc_d2   <= 3'd0;
      bytes_d2 <= 16'd0;
      wcc_cnt  <= 2'd0;
    end else begin
      rxd_d2   <= rxd_d1;
      rcv_d2   <= rcv_d1;
      term_d2  <= term_d1;
      err_d2   <= err_d1;
      tl_d2    <= tl_d1;
      loc_d2   <= loc_d1;
      bytes_d2 <= bytes_d1;
      // Loaded the cycle after get_terminator, counts 3 -> 1; a fresh
      // terminator inside the window restarts it.
      if (term_d2)              wcc_cnt <= 2'd3;
      else if (wcc_cnt != 2'd0) wcc_cnt <= wcc_cnt - 2'd1;
    end
  end

  assign bus.rxd64_d2            = rxd_d2;
  assign bus.receiving_d2        = rcv_d2;
  assign bus.get_terminator      = term_d2;
  assign bus.terminator_location = loc_d2;
  assign bus.frame_bytes         = bytes_d2;
  assign bus.frame_error         = err_d2;
  assign bus.frame_too_long      = tl_d2;
  assign bus.wait_crc_check      = |wcc_cnt;

endmodule
